// File: rtl/mux31_rr_arbiter_if.sv
// Handshake bundle between three requesters, the 3:1 round-robin arbiter and the
// downstream consumer of the selected word.
interface mux31_rr_arbiter_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNTW  = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [2:0]       req;
  logic [2:0]       ack;
  logic [WIDTH-1:0] dataout;
  logic [1:0]       s;
  logic             out_valid;
  logic             out_ready;
  logic [CNTW-1:0]  xfer_cnt;

  modport slave (
    input  a, b, c, req, out_ready,
    output ack, dataout, s, out_valid, xfer_cnt
  );

  modport master (
    output a, b, c, req, out_ready,
    input  ack, dataout, s, out_valid, xfer_cnt
  );
endinterface

// File: rtl/mux31_rr_arbiter.sv
// Round-robin arbiter feeding a single-entry output buffer on a shared 3:1 mux path.
// Optional MUX31_ARB_LOCK_EN adds a 3-bit lock input that lets the last winner keep the grant.
module mux31_rr_arbiter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNTW  = 16
) (
  input logic               clk,
  input logic               reset,
`ifdef MUX31_ARB_LOCK_EN
  input logic [2:0]         lock,
`endif
  mux31_rr_arbiter_if.slave bus
);

  logic [WIDTH-1:0] r_dataout;
  logic [1:0]       r_s;
  logic             r_out_valid;
  logic [CNTW-1:0]  r_cnt;
  logic [1:0]       r_ptr;
`ifdef MUX31_ARB_LOCK_EN
  logic [1:0]       r_last;
  logic             r_last_vld;
`endif

  logic             w_accept;
  logic             w_win_vld;
  logic [1:0]       w_win;
  logic [2:0]       w_sum;
  logic [1:0]       w_idx;
  logic             w_hold;
  logic             w_grant;
  logic [2:0]       w_ack;
  logic [WIDTH-1:0] w_sel;
  logic             w_drain;

  always_comb begin
    w_accept  = ~r_out_valid | bus.out_ready;
    w_drain   = r_out_valid & bus.out_ready;
    w_win     = 2'd0;
    w_win_vld = 1'b0;
    w_sum     = 3'd0;
    w_idx     = 2'd0;
    w_hold    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w_sum = {1'b0, r_ptr} + 3'(k);
      w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : 2'(w_sum);
      if (!w_win_vld && bus.req[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
`ifdef MUX31_ARB_LOCK_EN
    // A locked last winner that still requests pre-empts the rotation and freezes ptr.
    if (r_last_vld && lock[r_last] && bus.req[r_last]) begin
      w_win     = r_last;
      w_win_vld = 1'b1;
      w_hold    = 1'b1;
    end
`endif
    w_grant = w_accept & w_win_vld & ~reset;
    w_ack   = w_grant ? (3'b001 << w_win) : 3'b000;
    unique case (w_win)
      2'd0:    w_sel = bus.a;
      2'd1:    w_sel = bus.b;
      default: w_sel = bus.c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dataout   <= '0;
      r_s         <= 2'd0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_ptr       <= 2'd0;
`ifdef MUX31_ARB_LOCK_EN
      r_last      <= 2'd0;
      r_last_vld  <= 1'b0;
`endif
    end else begin
      if (w_drain) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_grant) begin
        r_dataout   <= w_sel;
        r_s         <= w_win;
        r_out_valid <= 1'b1;
        if (!w_hold) begin
          r_ptr <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
        end
`ifdef MUX31_ARB_LOCK_EN
        r_last     <= w_win;
        r_last_vld <= 1'b1;
`endif
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.ack       = w_ack;
  assign bus.dataout   = r_dataout;
  assign bus.s         = r_s;
  assign bus.out_valid = r_out_valid;
  assign bus.xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_mux31_rr_arbiter.sv
// Directed, table-driven bench for mux31_rr_arbiter, plus counter-wrap and lock sequences.
module tb_mux31_rr_arbiter;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  logic [2:0] lock;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux31_rr_arbiter_if #(.WIDTH(10), .CNTW(16)) bus0 ();
  mux31_rr_arbiter_if #(.WIDTH(10), .CNTW(4))  bus1 ();

  mux31_rr_arbiter #(.WIDTH(10), .CNTW(16)) dut0 (
    .clk   (clk),
    .reset (rst0),
`ifdef MUX31_ARB_LOCK_EN
    .lock  (lock),
`endif
    .bus   (bus0)
  );

  mux31_rr_arbiter #(.WIDTH(10), .CNTW(4)) dut1 (
    .clk   (clk),
    .reset (rst1),
`ifdef MUX31_ARB_LOCK_EN
    .lock  (3'b000),
`endif
    .bus   (bus1)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [9:0]  a;
    logic [9:0]  b;
    logic [9:0]  c;
    logic        rdy;
    logic [2:0]  ack;
    logic [9:0]  dout;
    logic [1:0]  s;
    logic        vld;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic [2:0] req, logic [9:0] a, logic [9:0] b,
                              logic [9:0] c, logic rdy, logic [2:0] ack, logic [9:0] dout,
                              logic [1:0] s, logic vld, logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.a = a; v.b = b; v.c = c; v.rdy = rdy;
    v.ack = ack; v.dout = dout; v.s = s; v.vld = vld; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step0(input logic [2:0] req, input logic rdy, input logic [2:0] exp_ack,
                       input string name);
    @(negedge clk);
    bus0.req       = req;
    bus0.out_ready = rdy;
    #1 check(name, {29'd0, bus0.ack}, {29'd0, exp_ack});
    @(posedge clk);
  endtask

  initial begin
    vecs[0]  = mk(1, 3'b111, 10'h1,   10'h2,   10'h2AA, 1, 3'b000, 10'h0,   0, 0, 0);
    vecs[1]  = mk(1, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b000, 10'h0,   0, 0, 0);
    vecs[2]  = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b001, 10'h1,   0, 1, 0);
    vecs[3]  = mk(0, 3'b010, 10'h7,   10'h155, 10'h3,   1, 3'b010, 10'h155, 1, 1, 1);
    vecs[4]  = mk(0, 3'b010, 10'h7,   10'h2AA, 10'h3,   1, 3'b010, 10'h2AA, 1, 1, 2);
    vecs[5]  = mk(0, 3'b100, 10'h1,   10'h2,   10'h3,   1, 3'b100, 10'h3,   2, 1, 3);
    vecs[6]  = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b001, 10'h1,   0, 1, 4);
    vecs[7]  = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b010, 10'h2,   1, 1, 5);
    vecs[8]  = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b100, 10'h3,   2, 1, 6);
    vecs[9]  = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b001, 10'h1,   0, 1, 7);
    vecs[10] = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b010, 10'h2,   1, 1, 8);
    vecs[11] = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b100, 10'h3,   2, 1, 9);
    vecs[12] = mk(0, 3'b000, 10'h11,  10'h22,  10'h33,  1, 3'b000, 10'h3,   2, 0, 10);
    vecs[13] = mk(0, 3'b000, 10'h11,  10'h22,  10'h33,  1, 3'b000, 10'h3,   2, 0, 10);
    vecs[14] = mk(0, 3'b001, 10'h3FF, 10'h2,   10'h3,   0, 3'b001, 10'h3FF, 0, 1, 10);
    vecs[15] = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   0, 3'b000, 10'h3FF, 0, 1, 10);
    vecs[16] = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   0, 3'b000, 10'h3FF, 0, 1, 10);
    vecs[17] = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   0, 3'b000, 10'h3FF, 0, 1, 10);
    vecs[18] = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   0, 3'b000, 10'h3FF, 0, 1, 10);
    vecs[19] = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   0, 3'b000, 10'h3FF, 0, 1, 10);
    vecs[20] = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b010, 10'h2,   1, 1, 11);
    vecs[21] = mk(1, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b000, 10'h0,   0, 0, 0);
    vecs[22] = mk(0, 3'b111, 10'h1,   10'h2,   10'h3,   1, 3'b001, 10'h1,   0, 1, 0);

    lock           = 3'b000;
    rst0           = 1'b1;
    rst1           = 1'b1;
    bus0.req       = 3'b000;
    bus0.a         = '0;
    bus0.b         = '0;
    bus0.c         = '0;
    bus0.out_ready = 1'b0;
    bus1.req       = 3'b000;
    bus1.a         = 10'h0AB;
    bus1.b         = '0;
    bus1.c         = '0;
    bus1.out_ready = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst0           = vecs[i].rst;
      bus0.req       = vecs[i].req;
      bus0.a         = vecs[i].a;
      bus0.b         = vecs[i].b;
      bus0.c         = vecs[i].c;
      bus0.out_ready = vecs[i].rdy;
      #1 check($sformatf("v%0d_ack", i), {29'd0, bus0.ack}, {29'd0, vecs[i].ack});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_dout", i), {22'd0, bus0.dataout}, {22'd0, vecs[i].dout});
      check($sformatf("v%0d_s", i), {30'd0, bus0.s}, {30'd0, vecs[i].s});
      check($sformatf("v%0d_vld", i), {31'd0, bus0.out_valid}, {31'd0, vecs[i].vld});
      check($sformatf("v%0d_cnt", i), {16'd0, bus0.xfer_cnt}, vecs[i].cnt);
    end

    // Counter wrap on the CNTW=4 instance: handshakes start one edge after the first grant.
    @(negedge clk);
    rst1 = 1'b0;
    bus1.req = 3'b001;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      if (k >= 15) begin
        check($sformatf("wrap_cnt_e%0d", k), {28'd0, bus1.xfer_cnt}, 32'((k - 1) % 16));
      end
    end

`ifdef MUX31_ARB_LOCK_EN
    @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    bus0.a = 10'h1;
    bus0.b = 10'h2;
    bus0.c = 10'h3;
    step0(3'b111, 1'b1, 3'b001, "lock_first");
    lock = 3'b001;
    for (int k = 0; k < 4; k++) step0(3'b111, 1'b1, 3'b001, $sformatf("lock_hold%0d", k));
    #1 check("lock_s", {30'd0, bus0.s}, 32'd0);
    lock = 3'b000;
    step0(3'b111, 1'b1, 3'b010, "unlock_b");
    step0(3'b111, 1'b1, 3'b100, "unlock_c");
    step0(3'b111, 1'b1, 3'b001, "unlock_a");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux31_rr_arbiter.md
Name: mux31_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 3:1 WIDTH-bit multiplexer datapath.
- Three requesters (a, b, c) each present a data word with a valid/ready handshake.
- The block grants one requester per cycle, drives the 2-bit mux select and registers the selected word into a single-entry output buffer with valid/ready to the downstream consumer.
- Sits between the operand sources and the shared consumer of the 3:1 select path.

Parameters:
- WIDTH, 10, data width of each source and of dataout.
- CNTW, 16, width of the transfer counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  requester 0 data.
- b  input  WIDTH  requester 1 data.
- c  input  WIDTH  requester 2 data.
- req  input  3  per-requester valid; bit0=a, bit1=b, bit2=c.
- ack  output  3  per-requester ready, one-hot or zero; combinational.
- dataout  output  WIDTH  registered selected word.
- s  output  2  registered select of the word in dataout: 00=a, 01=b, 10=c; 11 never driven.
- out_valid  output  1  dataout holds a word not yet taken.
- out_ready  input  1  consumer accepts dataout this cycle.
- xfer_cnt  output  CNTW  count of completed output handshakes.

Behaviour:
- Clocking and reset: single clock domain (clk); reset is synchronous and active-high (reset sampled on rising edge of clk).
- Reset values: dataout=0, s=00, out_valid=0, xfer_cnt=0, internal pointer ptr=0. ack=000 while reset is high.
- Reset mid-operation: any buffered word is discarded. No ack is asserted in the reset cycle.
- Buffer-accept condition: accept = ~out_valid | out_ready.
- Arbitration:
  - ptr ∈ {0,1,2}.
  - Search order: ptr, (ptr+1) mod 3, (ptr+2) mod 3.
  - The winner is the first index with req set.
  - ack[winner]=1 only when accept=1 and some req is set; otherwise ack=000.
  - ack may depend combinationally on req. Requesters must not make req depend on ack.
- Grant (req[i] & ack[i]) at edge:
  - dataout <= selected source word.
  - s <= i.
  - out_valid <= 1.
  - ptr <= (i+1) mod 3.
- Latency: a granted word appears on dataout/out_valid exactly 1 cycle after its grant cycle.
- Throughput: with out_ready held 1, one word per cycle, back-to-back.
- No grant while accept=1:
  - If out_valid & out_ready, then out_valid <= 0; dataout and s hold their last values.
- Backpressure (out_valid=1, out_ready=0): ack=000; dataout, s, out_valid and ptr all hold.
- Simultaneous drain and grant (out_valid=1, out_ready=1, a req present): the old word is consumed and the new word is loaded in the same edge; out_valid stays 1.
- xfer_cnt: increments by 1 on each edge with out_valid & out_ready. Wraps from all-ones to 0 with no flag.
- ptr only changes on a grant. Idle cycles do not rotate priority.
- Requester data is sampled only in its grant cycle. Data may change freely at other times.

Optional Feature:
- Macro: MUX31_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (3 bits).
  - If the last granted index L satisfies lock[L]=1 and req[L]=1, then L wins regardless of ptr, and ptr is not advanced.
  - After reset, L is treated as none; lock has no effect until the first grant.
  - Lock never overrides backpressure.
- Undefined: lock port is absent; pure round-robin as above.

Test Plan:
1. Reset: assert reset 2 cycles with req=111 and out_ready=1 → ack=000, out_valid=0, dataout=0, s=00, xfer_cnt=0. First grant after release goes to a (ack=001).
2. Single source: req=010, b=10'h155 then 10'h2AA on consecutive cycles, out_ready=1 → ack=010 every cycle; dataout=155 then 2AA one cycle later each; s=01; out_valid continuous; xfer_cnt increments each cycle.
3. Fairness: req=111 held, out_ready=1, a=1, b=2, c=3 → s sequence 00,01,10,00,01,10; dataout sequence 1,2,3,1,2,3.
4. Backpressure: buffer full with dataout=3FF, out_ready=0 for 5 cycles, req=111 → ack=000, dataout=3FF and s held, xfer_cnt unchanged. On out_ready=1, drain and next grant occur on the same edge.
5. Counter wrap: set CNTW=4 and complete 17 handshakes → xfer_cnt reads 15 after 15 transfers, 0 after 16, 1 after 17.
6. Lock (MUX31_ARB_LOCK_EN defined): req=111, lock=001 after the first grant to a → a granted 4 consecutive cycles. Then drop lock → next grants go b, c, a.
